// File: rtl/sample_rate_gen.sv
// sample_rate_gen: generates the one-cycle startsamplenow strobe that paces flash
// sample reads. The period is a runtime clock divisor. Synchronised keyboard speed
// commands step the divisor, and a new divisor takes effect only on a period boundary.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          1 = generate strobes, 0 = hold the counter idle
//   speed_up_in     raw key level; a rising edge shrinks the divisor
//   speed_down_in   raw key level; a rising edge grows the divisor
//   speed_rst_in    raw key level; a rising edge restores DEFAULT_DIV
//   startsamplenow  registered one-cycle strobe, one per active period
//   divisor         pending divisor (applied at the next boundary)
//   at_limit        1 when the pending divisor sits at DIV_MIN or DIV_MAX
//
// Build option: define SAMPLE_RATE_GEN_AUTOREPEAT_EN to auto-repeat held up/down keys
// every REPEAT_CYCLES cycles after the edge command.
module sample_rate_gen #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DEFAULT_DIV   = 2272,
    parameter int unsigned DIV_STEP      = 64,
    parameter int unsigned DIV_MIN       = 568,
    parameter int unsigned DIV_MAX       = 9088,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             speed_up_in,
    input  logic             speed_down_in,
    input  logic             speed_rst_in,
    output logic             startsamplenow,
    output logic [CNT_W-1:0] divisor,
    output logic             at_limit
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] MAX_D = CNT_W'(DIV_MAX);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   STP_X = (CNT_W+1)'(DIV_STEP);
    localparam logic [CNT_W:0]   MIN_X = (CNT_W+1)'(DIV_MIN);
    localparam logic [CNT_W:0]   MAX_X = (CNT_W+1)'(DIV_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             strobe_d;
    logic [CNT_W-1:0] pend_d;
    logic             lim_d;
    logic [CNT_W:0]   dec, inc;

    // Key bits: [0] up, [1] down, [2] rst
    logic [2:0] s1_q, s2_q, prev_q;
    logic [2:0] edge_cmd;
    logic       cmd_up, cmd_dn, cmd_rst;
    logic       sel_up, sel_dn;

    assign edge_cmd = s2_q & ~prev_q;

`ifdef SAMPLE_RATE_GEN_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q;
    logic             held, rpt_clr, rpt_fire;

    assign held     = s2_q[0] | s2_q[1];
    // Any edge command (including rst) restarts the repeat interval
    assign rpt_clr  = ~held | (|edge_cmd);
    assign rpt_fire = ~rpt_clr & (rpt_q == RPT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else if (rpt_clr || rpt_fire) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_q + 1'b1;
        end
    end

    assign cmd_up  = edge_cmd[0] | (rpt_fire & s2_q[0]);
    assign cmd_dn  = edge_cmd[1] | (rpt_fire & s2_q[1]);
    assign cmd_rst = edge_cmd[2];
`else
    assign cmd_up  = edge_cmd[0];
    assign cmd_dn  = edge_cmd[1];
    assign cmd_rst = edge_cmd[2];
`endif

    // rst beats up beats down; the losers are dropped
    assign sel_up = cmd_up & ~cmd_rst;
    assign sel_dn = cmd_dn & ~cmd_up & ~cmd_rst;

    always_comb begin
        pend_d = divisor;
        dec    = {1'b0, divisor} - STP_X;
        inc    = {1'b0, divisor} + STP_X;
        unique case (1'b1)
            cmd_rst: pend_d = DEF_D;
            sel_up: begin
                // The extra top bit catches underflow below zero
                if (dec[CNT_W] || dec < MIN_X) pend_d = MIN_D;
                else                           pend_d = dec[CNT_W-1:0];
            end
            sel_dn: begin
                if (inc > MAX_X) pend_d = MAX_D;
                else             pend_d = inc[CNT_W-1:0];
            end
            default: ;
        endcase
        lim_d = (pend_d == MIN_D) || (pend_d == MAX_D);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        strobe_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                    act_d   = divisor;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abandon the current period without a strobe
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == act_q - ONE) begin
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                    act_d    = divisor;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            act_q          <= DEF_D;
            divisor        <= DEF_D;
            startsamplenow <= 1'b0;
            at_limit       <= 1'b0;
            s1_q           <= '0;
            s2_q           <= '0;
            prev_q         <= '0;
        end else begin
            cnt_q          <= cnt_d;
            act_q          <= act_d;
            divisor        <= pend_d;
            startsamplenow <= strobe_d;
            at_limit       <= lim_d;
            s1_q           <= {speed_rst_in, speed_down_in, speed_up_in};
            s2_q           <= s1_q;
            prev_q         <= s2_q;
        end
    end

endmodule

// File: tb/tb_sample_rate_gen.sv
// tb_sample_rate_gen: randomized speed commands and enable toggles for sample_rate_gen,
// checked against a behavioural reference model.
module tb_sample_rate_gen;

    localparam int DEF  = 2272;
    localparam int STEP = 64;
    localparam int DMIN = 568;
    localparam int DMAX = 9088;
    localparam int RPT  = 100;

    logic        clk, rst_n, enable;
    logic        up, dn, rk;
    logic        startsamplenow, at_limit;
    logic [15:0] divisor;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int  m_pend = DEF;
    bit  m_run = 0;
    int  exp_next = 0;
    bit  exp_strobe = 0;
    int  cyc = 0;
    int  n_strobe = 0;

    sample_rate_gen #(
        .CNT_W(16), .DEFAULT_DIV(DEF), .DIV_STEP(STEP),
        .DIV_MIN(DMIN), .DIV_MAX(DMAX), .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .speed_up_in(up), .speed_down_in(dn), .speed_rst_in(rk),
        .startsamplenow(startsamplenow), .divisor(divisor), .at_limit(at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int step(input int p, input bit u, input bit d, input bit r);
        if (r) return DEF;
        if (u) return (p - STEP < DMIN) ? DMIN : p - STEP;
        if (d) return (p + STEP > DMAX) ? DMAX : p + STEP;
        return p;
    endfunction

    // Strobe schedule: each period lasts the pending value seen just before its start edge
    always @(posedge clk) begin
        cyc++;
        exp_strobe = 0;
        if (!rst_n) begin
            m_run = 0;
        end else if (!m_run) begin
            if (enable) begin
                m_run    = 1;
                exp_next = cyc + m_pend;
            end
        end else if (!enable) begin
            m_run = 0;
        end else if (cyc == exp_next) begin
            exp_strobe = 1;
            exp_next   = cyc + m_pend;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (startsamplenow || exp_strobe))
            check("strobe", int'(startsamplenow), int'(exp_strobe));
        if (rst_n && startsamplenow) n_strobe++;
    end

    task automatic send(input bit u, input bit d, input bit r, input int hold);
        @(negedge clk);
        up = u; dn = d; rk = r;
        repeat (2) @(negedge clk);
        check("div_early", int'(divisor), m_pend);
        @(negedge clk);
        m_pend = step(m_pend, u, d, r);
        check("div", int'(divisor), m_pend);
        repeat (hold) @(negedge clk);
        up = 0; dn = 0; rk = 0;
        repeat (3) @(negedge clk);
        check("div_held", int'(divisor), m_pend);
        check("at_limit", int'(at_limit), int'(m_pend == DMIN || m_pend == DMAX));
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (startsamplenow) begin
                k = i;
                break;
            end
        end
        if (k == 0) check("strobe_timeout", 0, 1);
    endtask

    initial begin
        int k, ns, bits, g;
        rst_n = 1; enable = 0; up = 0; dn = 0; rk = 0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_strobe", int'(startsamplenow), 0);
        check("rst_div", int'(divisor), DEF);
        check("rst_lim", int'(at_limit), 0);
        rst_n = 1;
        @(negedge clk);

        enable = 1;
        repeat (5000) @(negedge clk);
        check("n_strobe_def", n_strobe, 2);

        send(1, 0, 0, 2);
        repeat (3000) @(negedge clk);

        repeat (30) send(1, 0, 0, 0);
        check("sat_min", int'(divisor), DMIN);
        send(1, 0, 0, 1);
        send(0, 1, 0, 0);
        check("min_plus", int'(divisor), DMIN + STEP);

        for (int n = 0; n < 40; n++) begin
            bits = $urandom_range(1, 7);
            send(bits[0], bits[1], bits[2], $urandom_range(0, 4));
            g = $urandom_range(0, 20);
            repeat (g) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                enable = 0;
                g = $urandom_range(0, 600);
                repeat (g) @(negedge clk);
                enable = 1;
            end
        end

        send(1, 0, 1, 0);
        check("rst_beats_up", int'(divisor), DEF);
        repeat (110) send(0, 1, 0, 0);
        check("sat_max", int'(divisor), DMAX);
        send(0, 0, 1, 0);

        wait_strobe(k);
        repeat (1000) @(negedge clk);
        enable = 0;
        ns = n_strobe;
        repeat (3000) @(negedge clk);
        check("idle_quiet", n_strobe, ns);
        enable = 1;
        wait_strobe(k);
        check("reen_latency", k, m_pend + 1);

`ifdef SAMPLE_RATE_GEN_AUTOREPEAT_EN
        @(negedge clk);
        up = 1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        m_pend = step(m_pend, 1, 0, 0);
        check("rpt_edge", int'(divisor), m_pend);
        for (int r = 0; r < 3; r++) begin
            repeat (RPT - 1) @(negedge clk);
            check("rpt_early", int'(divisor), m_pend);
            @(negedge clk);
            m_pend = step(m_pend, 1, 0, 0);
            check("rpt_step", int'(divisor), m_pend);
        end
        repeat (50) @(negedge clk);
        up = 0;
        repeat (3) @(negedge clk);
        check("rpt_final", int'(divisor), DEF - 4 * STEP);
`endif

        repeat (30) send(1, 0, 0, 0);
        wait_strobe(k);
        #2 rst_n = 0;
        #1;
        m_pend = DEF;
        check("arst_strobe", int'(startsamplenow), 0);
        check("arst_div", int'(divisor), DEF);
        check("arst_lim", int'(at_limit), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
